// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM: decodes op/funct into datapath enables,
// stalls on mem_ready, counts retired instructions and flags illegal opcodes.
module multicycle_controller #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [2:0]           alu_control,
  output logic                 reg_write,
  output logic                 illegal,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t     cur, nxt;
  logic       retire;
  logic       pc_w, mem_w, ir_w, reg_w;
  logic [2:0] funct_alu;

  always_comb begin
    case (funct3)
      3'b000:  funct_alu = (op[5] & funct7[5]) ? 3'b001 : 3'b000;
      3'b010:  funct_alu = 3'b101;
      3'b110:  funct_alu = 3'b011;
      3'b111:  funct_alu = 3'b010;
      default: funct_alu = 3'b000;
    endcase
  end

  always_comb begin
    nxt    = cur;
    retire = 1'b0;
    case (cur)
      FETCH:    if (mem_ready) nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: nxt = MEMADR;
          OP_RTYPE:          nxt = EXECR;
          OP_ITYPE:          nxt = EXECI;
          OP_BEQ:            nxt = BEQ;
          OP_JAL:            nxt = JAL;
          default:           nxt = TRAP;
        endcase
      end
      MEMADR:   nxt = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) nxt = MEMWB;
      MEMWB: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
      MEMWRITE: if (mem_ready) begin
        nxt    = FETCH;
        retire = 1'b1;
      end
      EXECR, EXECI: nxt = ALUWB;
      ALUWB, BEQ: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
      JAL:      nxt = ALUWB;
      TRAP:     nxt = TRAP;
      default:  nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur     <= FETCH;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      cur <= nxt;
      if (retire) retired <= retired + CNT_WIDTH'(1);
      if (nxt == TRAP) illegal <= 1'b1;
    end
  end

  always_comb begin
    pc_w        = 1'b0;
    mem_w       = 1'b0;
    ir_w        = 1'b0;
    reg_w       = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    case (cur)
      FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_w       = mem_ready;
        pc_w       = mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD:  adr_src = 1'b1;
      MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = funct_alu;
      end
      EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = funct_alu;
      end
      ALUWB:    reg_w = 1'b1;
      BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        pc_w        = zero;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_w      = 1'b1;
      end
      default: ;
    endcase
  end

  // State sits in FETCH during reset, so the enables are gated by rst directly
  assign pc_write  = pc_w & rst;
  assign mem_write = mem_w & rst;
  assign ir_write  = ir_w & rst;
  assign reg_write = reg_w & rst;

  always_comb begin
    case (op)
      OP_STORE: imm_src = 2'b01;
      OP_BEQ:   imm_src = 2'b10;
      OP_JAL:   imm_src = 2'b11;
      default:  imm_src = 2'b00;
    endcase
  end

  assign state = cur;

endmodule
